// File: rtl/aximm_if.sv
// AXI-MM bus bundle between an initiator (master) and a subordinate (slave).
// Carries the five AW/W/B/AR/R channels with parameterisable field widths.
interface aximm_if #(
  parameter int AXI4_IDW       = 8,
  parameter int AXI4_ADDRW     = 64,
  parameter int AXI4_LENW      = 8,
  parameter int AXI4_SIZEW     = 3,
  parameter int AXI4_BURSTW    = 2,
  parameter int AXI4_USERW     = 64,
  parameter int AXI4_MAX_DATAW = 512,
  parameter int AXI4_RESPW     = 2
);
  logic                      awvalid;
  logic                      awready;
  logic [AXI4_IDW-1:0]       awid;
  logic [AXI4_ADDRW-1:0]     awaddr;
  logic [AXI4_LENW-1:0]      awlen;
  logic [AXI4_SIZEW-1:0]     awsize;
  logic [AXI4_BURSTW-1:0]    awburst;
  logic [AXI4_USERW-1:0]     awuser;

  logic                      wvalid;
  logic                      wready;
  logic [AXI4_IDW-1:0]       wid;
  logic [AXI4_MAX_DATAW-1:0] wdata;
  logic                      wlast;
  logic [AXI4_USERW-1:0]     wuser;

  logic                      bvalid;
  logic                      bready;
  logic [AXI4_IDW-1:0]       bid;
  logic [AXI4_RESPW-1:0]     bresp;
  logic [AXI4_USERW-1:0]     buser;

  logic                      arvalid;
  logic                      arready;
  logic [AXI4_IDW-1:0]       arid;
  logic [AXI4_ADDRW-1:0]     araddr;
  logic [AXI4_LENW-1:0]      arlen;
  logic [AXI4_SIZEW-1:0]     arsize;
  logic [AXI4_BURSTW-1:0]    arburst;
  logic [AXI4_USERW-1:0]     aruser;

  logic                      rvalid;
  logic                      rready;
  logic [AXI4_IDW-1:0]       rid;
  logic [AXI4_MAX_DATAW-1:0] rdata;
  logic [AXI4_RESPW-1:0]     rresp;
  logic                      rlast;
  logic [AXI4_USERW-1:0]     ruser;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst, awuser,
    input  awready,
    output wvalid, wid, wdata, wlast, wuser,
    input  wready,
    input  bvalid, bid, bresp, buser,
    output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst, aruser,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast, ruser,
    output rready
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst, awuser,
    output awready,
    input  wvalid, wid, wdata, wlast, wuser,
    output wready,
    output bvalid, bid, bresp, buser,
    input  bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst, aruser,
    output arready,
    output rvalid, rid, rdata, rresp, rlast, ruser,
    input  rready
  );
endinterface

// File: rtl/aximm_mem_server.sv
// AXI-MM subordinate backed by a small register-file word memory.
// Independent write (AW/W/B) and read (AR/R) engines, one outstanding burst each.
module aximm_mem_server #(
  parameter int DEPTH          = 16,
  parameter int DATAW          = 64,
  parameter int AXI4_IDW       = 8,
  parameter int AXI4_ADDRW     = 64,
  parameter int AXI4_LENW      = 8,
  parameter int AXI4_SIZEW     = 3,
  parameter int AXI4_BURSTW    = 2,
  parameter int AXI4_USERW     = 64,
  parameter int AXI4_MAX_DATAW = 512,
  parameter int AXI4_RESPW     = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  aximm_if.slave aximm_server
);
  localparam int MEMW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // The top four address bits carry the NoC node ID; the rest is the word index.
  localparam int IDXW = AXI4_ADDRW - 4;

  localparam logic [AXI4_RESPW-1:0]  RESP_OKAY   = AXI4_RESPW'(0);
  localparam logic [AXI4_RESPW-1:0]  RESP_SLVERR = AXI4_RESPW'(2);
  localparam logic [AXI4_BURSTW-1:0] BURST_FIXED = AXI4_BURSTW'(0);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  logic [DATAW-1:0] mem [DEPTH];

  function automatic logic [IDXW-1:0] addr_idx(input logic [AXI4_ADDRW-1:0] a);
    return a[IDXW-1:0];
  endfunction

  function automatic logic idx_oob(input logic [IDXW-1:0] i);
    return i >= IDXW'(DEPTH);
  endfunction

  // WRAP and any non-FIXED burst walk upward like INCR.
  function automatic logic [IDXW-1:0] idx_next(input logic [IDXW-1:0] i,
                                               input logic [AXI4_BURSTW-1:0] b);
    return (b == BURST_FIXED) ? i : i + 1'b1;
  endfunction

  function automatic logic [AXI4_MAX_DATAW-1:0] mem_word(input logic [IDXW-1:0] i);
    if (idx_oob(i)) return '0;
    return AXI4_MAX_DATAW'(mem[i[MEMW-1:0]]);
  endfunction

  function automatic logic [AXI4_RESPW-1:0] idx_resp(input logic [IDXW-1:0] i);
    return idx_oob(i) ? RESP_SLVERR : RESP_OKAY;
  endfunction

  wstate_t                 w_state;
  logic [AXI4_IDW-1:0]     w_id;
  logic [IDXW-1:0]         w_idx;
  logic [AXI4_LENW-1:0]    w_len;
  logic [AXI4_LENW-1:0]    w_cnt;
  logic [AXI4_BURSTW-1:0]  w_burst;
  logic [AXI4_USERW-1:0]   w_user;
  logic                    w_err;
  logic                    w_last_beat;
  logic                    w_beat_err;

  rstate_t                 r_state;
  logic [IDXW-1:0]         r_idx;
  logic [IDXW-1:0]         r_idx_nxt;
  logic [AXI4_LENW-1:0]    r_len;
  logic [AXI4_LENW-1:0]    r_cnt;
  logic [AXI4_LENW-1:0]    r_cnt_nxt;
  logic [AXI4_BURSTW-1:0]  r_burst;
  logic [IDXW-1:0]         ar_idx;

  assign w_last_beat = (w_cnt == w_len);
  // wlast is only cross-checked; the burst always ends on the beat count.
  assign w_beat_err  = idx_oob(w_idx) || (aximm_server.wlast != w_last_beat);
  assign r_idx_nxt   = idx_next(r_idx, r_burst);
  assign r_cnt_nxt   = r_cnt + 1'b1;
  assign ar_idx      = addr_idx(aximm_server.araddr);

  logic unused_sigs;
  assign unused_sigs = ^{aximm_server.awaddr[AXI4_ADDRW-1:IDXW],
                         aximm_server.araddr[AXI4_ADDRW-1:IDXW],
                         aximm_server.awsize, aximm_server.arsize,
                         aximm_server.wid, aximm_server.wuser,
                         aximm_server.wdata};

  // Write engine: owns the memory array and the AW/W/B outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state              <= W_IDLE;
      w_cnt                <= '0;
      w_err                <= 1'b0;
      aximm_server.awready <= 1'b0;
      aximm_server.wready  <= 1'b0;
      aximm_server.bvalid  <= 1'b0;
      aximm_server.bid     <= '0;
      aximm_server.bresp   <= '0;
      aximm_server.buser   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          aximm_server.awready <= 1'b1;
          if (aximm_server.awvalid && aximm_server.awready) begin
            w_id                 <= aximm_server.awid;
            w_idx                <= addr_idx(aximm_server.awaddr);
            w_len                <= aximm_server.awlen;
            w_burst              <= aximm_server.awburst;
            w_user               <= aximm_server.awuser;
            w_cnt                <= '0;
            w_err                <= 1'b0;
            aximm_server.awready <= 1'b0;
            aximm_server.wready  <= 1'b1;
            w_state              <= W_DATA;
          end
        end
        W_DATA: begin
          if (aximm_server.wvalid && aximm_server.wready) begin
            if (!idx_oob(w_idx)) mem[w_idx[MEMW-1:0]] <= aximm_server.wdata[DATAW-1:0];
            if (w_last_beat) begin
              aximm_server.wready <= 1'b0;
              aximm_server.bvalid <= 1'b1;
              aximm_server.bid    <= w_id;
              aximm_server.buser  <= w_user;
              aximm_server.bresp  <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
              w_state             <= W_RESP;
            end else begin
              w_cnt <= w_cnt + 1'b1;
              w_idx <= idx_next(w_idx, w_burst);
              w_err <= w_err | w_beat_err;
            end
          end
        end
        W_RESP: begin
          if (aximm_server.bvalid && aximm_server.bready) begin
            aximm_server.bvalid  <= 1'b0;
            aximm_server.awready <= 1'b1;
            w_state              <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read engine: memory is sampled before same-edge writes land (read-first).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state              <= R_IDLE;
      r_cnt                <= '0;
      aximm_server.arready <= 1'b0;
      aximm_server.rvalid  <= 1'b0;
      aximm_server.rid     <= '0;
      aximm_server.rdata   <= '0;
      aximm_server.rresp   <= '0;
      aximm_server.rlast   <= 1'b0;
      aximm_server.ruser   <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          aximm_server.arready <= 1'b1;
          if (aximm_server.arvalid && aximm_server.arready) begin
            r_idx                <= ar_idx;
            r_len                <= aximm_server.arlen;
            r_burst              <= aximm_server.arburst;
            r_cnt                <= '0;
            aximm_server.arready <= 1'b0;
            aximm_server.rvalid  <= 1'b1;
            aximm_server.rid     <= aximm_server.arid;
            aximm_server.ruser   <= aximm_server.aruser;
            aximm_server.rdata   <= mem_word(ar_idx);
            aximm_server.rresp   <= idx_resp(ar_idx);
            aximm_server.rlast   <= (aximm_server.arlen == '0);
            r_state              <= R_DATA;
          end
        end
        R_DATA: begin
          if (aximm_server.rvalid && aximm_server.rready) begin
            if (aximm_server.rlast) begin
              aximm_server.rvalid  <= 1'b0;
              aximm_server.rlast   <= 1'b0;
              aximm_server.arready <= 1'b1;
              r_state              <= R_IDLE;
            end else begin
              r_idx              <= r_idx_nxt;
              r_cnt              <= r_cnt_nxt;
              aximm_server.rdata <= mem_word(r_idx_nxt);
              aximm_server.rresp <= idx_resp(r_idx_nxt);
              aximm_server.rlast <= (r_cnt_nxt == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aximm_mem_server.sv
// Bench for aximm_mem_server: directed table, corner sequences and
// randomized bursts checked against an array-based memory model.
module tb_aximm_mem_server;
  localparam int DEPTH = 16;
  localparam int MDW   = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aximm_if #(.AXI4_IDW(8), .AXI4_ADDRW(64), .AXI4_LENW(8), .AXI4_SIZEW(3),
             .AXI4_BURSTW(2), .AXI4_USERW(64), .AXI4_MAX_DATAW(MDW), .AXI4_RESPW(2)) bus();

  aximm_mem_server #(.DEPTH(DEPTH), .DATAW(64), .AXI4_IDW(8), .AXI4_ADDRW(64), .AXI4_LENW(8),
                     .AXI4_SIZEW(3), .AXI4_BURSTW(2), .AXI4_USERW(64),
                     .AXI4_MAX_DATAW(MDW), .AXI4_RESPW(2))
    dut (.clk(clk), .rst_n(rst_n), .aximm_server(bus));

  int compared = 0;
  int mismatched = 0;
  logic [63:0] ref_mem [DEPTH];

  typedef struct {
    logic [59:0] widx;
    int          len;
    logic [1:0]  burst;
    int          wl;
    logic [63:0] base;
    logic [1:0]  exp_bresp;
    logic [59:0] cidx;
    logic [63:0] exp_word;
    logic [1:0]  exp_rresp;
  } vec_t;

  task automatic chk(input string nm, input logic [MDW-1:0] act, input logic [MDW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return bus.awready;
      1: return bus.wready;
      2: return bus.bvalid;
      3: return bus.arready;
      4: return bus.rvalid;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_hi(input int sel, input string nm);
    int n = 0;
    while (sig(sel) !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      compared++;
      mismatched++;
      $display("FAIL %s: timeout, got 0 required 1", nm);
    end
  endtask

  function automatic logic [63:0] beat_data(input logic [63:0] base, input int k);
    return base * 64'(k + 1);
  endfunction

  // Reference: apply a write burst word by word and report the expected response.
  function automatic logic [1:0] model_write(input logic [59:0] idx0, input int len,
                                             input logic [1:0] burst, input int wl,
                                             input logic [63:0] base);
    logic [59:0] idx = idx0;
    logic err = 1'b0;
    for (int k = 0; k <= len; k++) begin
      if (idx < 60'(DEPTH)) ref_mem[idx[3:0]] = beat_data(base, k);
      else err = 1'b1;
      if ((k == wl) != (k == len)) err = 1'b1;
      if (burst != 2'b00) idx = idx + 60'd1;
    end
    return err ? 2'b10 : 2'b00;
  endfunction

  task automatic idle_inputs();
    bus.awvalid = 0; bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0;
    bus.awburst = '0; bus.awuser = '0;
    bus.wvalid = 0; bus.wid = '0; bus.wdata = '0; bus.wlast = 0; bus.wuser = '0;
    bus.bready = 0;
    bus.arvalid = 0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
    bus.arburst = '0; bus.aruser = '0;
    bus.rready = 0;
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_awready"}, MDW'(bus.awready), '0);
    chk({nm, "_wready"},  MDW'(bus.wready),  '0);
    chk({nm, "_bvalid"},  MDW'(bus.bvalid),  '0);
    chk({nm, "_bid"},     MDW'(bus.bid),     '0);
    chk({nm, "_bresp"},   MDW'(bus.bresp),   '0);
    chk({nm, "_buser"},   MDW'(bus.buser),   '0);
    chk({nm, "_arready"}, MDW'(bus.arready), '0);
    chk({nm, "_rvalid"},  MDW'(bus.rvalid),  '0);
    chk({nm, "_rid"},     MDW'(bus.rid),     '0);
    chk({nm, "_rdata"},   bus.rdata,         '0);
    chk({nm, "_rresp"},   MDW'(bus.rresp),   '0);
    chk({nm, "_rlast"},   MDW'(bus.rlast),   '0);
    chk({nm, "_ruser"},   MDW'(bus.ruser),   '0);
  endtask

  task automatic do_write(input logic [3:0] node, input logic [59:0] idx, input int len,
                          input logic [1:0] burst, input int wl, input logic [63:0] base,
                          input logic [7:0] id, input logic [63:0] user, input int bdelay,
                          output logic [1:0] bresp, output logic [7:0] bid,
                          output logic [63:0] buser);
    logic [447:0] junk;
    bus.awaddr = {node, idx}; bus.awlen = 8'(len); bus.awburst = burst;
    bus.awid = id; bus.awuser = user; bus.awsize = 3'd3; bus.awvalid = 1;
    wait_hi(0, "awready");
    @(negedge clk);
    bus.awvalid = 0;
    for (int k = 0; k <= len; k++) begin
      junk = {14{32'($urandom)}};
      bus.wdata = {junk, beat_data(base, k)};
      bus.wid = id; bus.wuser = user; bus.wlast = (k == wl); bus.wvalid = 1;
      wait_hi(1, "wready");
      @(negedge clk);
    end
    bus.wvalid = 0; bus.wlast = 0;
    wait_hi(2, "bvalid");
    for (int d = 0; d < bdelay; d++) begin
      chk("b_hold_bvalid",  MDW'(bus.bvalid),  MDW'(1'b1));
      chk("b_hold_bid",     MDW'(bus.bid),     MDW'(id));
      chk("b_hold_awready", MDW'(bus.awready), '0);
      @(negedge clk);
    end
    bus.bready = 1;
    bresp = bus.bresp; bid = bus.bid; buser = bus.buser;
    @(negedge clk);
    bus.bready = 0;
  endtask

  task automatic do_read(input logic [3:0] node, input logic [59:0] idx, input int len,
                         input logic [1:0] burst, input logic [7:0] id,
                         input logic [63:0] user, input bit rnd, input string nm,
                         output logic [MDW-1:0] d0, output logic [1:0] r0);
    logic [MDW-1:0] hd;
    logic [1:0] hr;
    logic hl;
    logic [59:0] ci;
    logic [MDW-1:0] ed;
    bit stalled = 0;
    int k = 0;
    int guard = 0;
    d0 = '0; r0 = '0; hd = '0; hr = '0; hl = 0;
    bus.araddr = {node, idx}; bus.arlen = 8'(len); bus.arburst = burst;
    bus.arid = id; bus.aruser = user; bus.arsize = 3'd3; bus.arvalid = 1;
    wait_hi(3, {nm, "_arready"});
    @(negedge clk);
    bus.arvalid = 0;
    while (k <= len && guard < 1000) begin
      guard++;
      chk({nm, "_rvalid"}, MDW'(bus.rvalid), MDW'(1'b1));
      if (stalled) begin
        chk({nm, "_hold_rdata"}, bus.rdata, hd);
        chk({nm, "_hold_rresp"}, MDW'(bus.rresp), MDW'(hr));
        chk({nm, "_hold_rlast"}, MDW'(bus.rlast), MDW'(hl));
      end
      bus.rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.rready) begin
        ci = idx + ((burst != 2'b00) ? 60'(k) : 60'd0);
        ed = (ci < 60'(DEPTH)) ? MDW'(ref_mem[ci[3:0]]) : '0;
        if (k == 0) begin d0 = bus.rdata; r0 = bus.rresp; end
        chk({nm, "_rdata"}, bus.rdata, ed);
        chk({nm, "_rresp"}, MDW'(bus.rresp), (ci < 60'(DEPTH)) ? MDW'(2'b00) : MDW'(2'b10));
        chk({nm, "_rlast"}, MDW'(bus.rlast), MDW'(k == len));
        chk({nm, "_rid"},   MDW'(bus.rid),   MDW'(id));
        chk({nm, "_ruser"}, MDW'(bus.ruser), MDW'(user));
        k++;
        stalled = 0;
      end else begin
        stalled = 1;
        hd = bus.rdata; hr = bus.rresp; hl = bus.rlast;
      end
      @(negedge clk);
    end
    bus.rready = 0;
    chk({nm, "_rvalid_end"}, MDW'(bus.rvalid), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    logic [1:0] bresp, exp_bresp, rresp;
    logic [7:0] bid;
    logic [63:0] buser, oldv, newv, base;
    logic [MDW-1:0] rd;
    logic [59:0] idx;
    int len, wl;
    logic [1:0] burst;

    vecs[0] = '{60'd3,  0, 2'b01, 0, 64'hDEADBEEF, 2'b00, 60'd3,  64'hDEADBEEF, 2'b00};
    vecs[1] = '{60'd4,  3, 2'b01, 3, 64'h11,       2'b00, 60'd7,  64'h44,       2'b00};
    vecs[2] = '{60'd7,  2, 2'b00, 2, 64'hA,        2'b00, 60'd7,  64'h1E,       2'b00};
    vecs[3] = '{60'd10, 2, 2'b01, 1, 64'h100,      2'b10, 60'd12, 64'h300,      2'b00};
    vecs[4] = '{60'd20, 0, 2'b01, 0, 64'h55,       2'b10, 60'd20, 64'h0,        2'b10};
    vecs[5] = '{60'd14, 3, 2'b01, 3, 64'h5,        2'b10, 60'd15, 64'hA,        2'b00};
    vecs[6] = '{60'd0,  1, 2'b10, 1, 64'h77,       2'b00, 60'd1,  64'hEE,       2'b00};

    idle_inputs();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1;
    @(negedge clk);
    chk("post_reset_awready", MDW'(bus.awready), MDW'(1'b1));
    chk("post_reset_arready", MDW'(bus.arready), MDW'(1'b1));

    // Directed table: write burst, then single-word readback.
    for (int i = 0; i < 7; i++) begin
      do_write(4'd2, vecs[i].widx, vecs[i].len, vecs[i].burst, vecs[i].wl, vecs[i].base,
               8'(5 + i), 64'(i * 3), 0, bresp, bid, buser);
      void'(model_write(vecs[i].widx, vecs[i].len, vecs[i].burst, vecs[i].wl, vecs[i].base));
      chk($sformatf("vec%0d_bresp", i), MDW'(bresp), MDW'(vecs[i].exp_bresp));
      chk($sformatf("vec%0d_bid", i),   MDW'(bid),   MDW'(8'(5 + i)));
      chk($sformatf("vec%0d_buser", i), MDW'(buser), MDW'(64'(i * 3)));
      do_read(4'd2, vecs[i].cidx, 0, 2'b01, 8'(5 + i), 64'h0, 0,
              $sformatf("vec%0d_rd", i), rd, rresp);
      chk($sformatf("vec%0d_word", i),  rd,          MDW'(vecs[i].exp_word));
      chk($sformatf("vec%0d_rresp", i), MDW'(rresp), MDW'(vecs[i].exp_rresp));
    end

    // INCR burst 11..44 at idx 4 with B held off for 6 cycles.
    do_write(4'd1, 60'd4, 3, 2'b01, 3, 64'h11, 8'h21, 64'hABCD, 6, bresp, bid, buser);
    void'(model_write(60'd4, 3, 2'b01, 3, 64'h11));
    chk("bp_bresp", MDW'(bresp), '0);
    chk("bp_bid",   MDW'(bid),   MDW'(8'h21));
    do_read(4'd1, 60'd4, 3, 2'b01, 8'h31, 64'h99, 0, "incr_rd", rd, rresp);
    chk("incr_rd_first", rd, MDW'(64'h11));
    do_read(4'd1, 60'd4, 3, 2'b01, 8'h32, 64'h98, 1, "toggle_rd", rd, rresp);
    do_read(4'd0, 60'd15, 1, 2'b01, 8'h33, 64'h1, 1, "edge15_rd", rd, rresp);
    chk("edge15_first_rresp", MDW'(rresp), '0);

    // Write and read of the same word on the same edge returns the old word.
    do_write(4'd0, 60'd2, 0, 2'b01, 0, 64'h2222, 8'h1, 64'h0, 0, bresp, bid, buser);
    void'(model_write(60'd2, 0, 2'b01, 0, 64'h2222));
    oldv = ref_mem[2];
    newv = 64'hA5A5_0000_1234_5678;
    bus.awaddr = {4'd1, 60'd2}; bus.awlen = 8'd0; bus.awburst = 2'b01; bus.awid = 8'd9;
    bus.awvalid = 1;
    wait_hi(0, "se_awready");
    @(negedge clk);
    bus.awvalid = 0;
    wait_hi(1, "se_wready");
    wait_hi(3, "se_arready");
    bus.wdata = {448'd0, newv}; bus.wlast = 1; bus.wvalid = 1;
    bus.araddr = {4'd1, 60'd2}; bus.arlen = 8'd0; bus.arburst = 2'b01; bus.arid = 8'd3;
    bus.aruser = '0; bus.arvalid = 1; bus.rready = 1;
    @(negedge clk);
    bus.wvalid = 0; bus.wlast = 0; bus.arvalid = 0;
    chk("same_edge_rvalid", MDW'(bus.rvalid), MDW'(1'b1));
    chk("same_edge_old",    bus.rdata,        MDW'(oldv));
    bus.bready = 1;
    wait_hi(2, "se_bvalid");
    @(negedge clk);
    bus.bready = 0; bus.rready = 0;
    ref_mem[2] = newv;
    do_read(4'd1, 60'd2, 0, 2'b01, 8'h4, 64'h0, 0, "same_edge_new", rd, rresp);

    // Randomized bursts against the model.
    for (int t = 0; t < 40; t++) begin
      idx = 60'($urandom_range(0, 19));
      len = $urandom_range(0, 4);
      burst = 2'($urandom_range(0, 2));
      wl = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : len;
      base = {32'($urandom), 32'($urandom)};
      do_write(4'($urandom_range(0, 15)), idx, len, burst, wl, base, 8'(t), 64'(t + 100),
               $urandom_range(0, 2), bresp, bid, buser);
      exp_bresp = model_write(idx, len, burst, wl, base);
      chk($sformatf("rnd%0d_bresp", t), MDW'(bresp), MDW'(exp_bresp));
      chk($sformatf("rnd%0d_bid", t),   MDW'(bid),   MDW'(8'(t)));
      do_read(4'($urandom_range(0, 15)), 60'($urandom_range(0, 19)), $urandom_range(0, 4),
              2'($urandom_range(0, 2)), 8'(t + 1), 64'(t), 1, $sformatf("rnd%0d_rd", t), rd, rresp);
    end

    // Reset in the middle of a read burst.
    bus.araddr = {4'd0, 60'd0}; bus.arlen = 8'd7; bus.arburst = 2'b01; bus.arvalid = 1;
    wait_hi(3, "mid_arready");
    @(negedge clk);
    bus.arvalid = 0; bus.rready = 1;
    repeat (2) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk_outputs_zero("mid_reset");
    bus.rready = 0;
    rst_n = 1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    @(negedge clk);
    do_read(4'd0, 60'd0, 15, 2'b01, 8'h7, 64'h0, 1, "cleared_rd", rd, rresp);
    chk("cleared_word0", rd, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
